// File: rtl/scrambler_pkg.sv
// Shared constants and LFSR step function for the additive scrambler.
// Optional runtime seed load is enabled by defining LFSR_SEED_LOAD_EN.
package scrambler_pkg;

   localparam int         LFSR_MAX_W  = 32;
   localparam logic [6:0] PRBS7_POLY  = 7'h60;
   localparam logic [6:0] PRBS7_SEED  = 7'h7F;
   localparam logic [14:0] PRBS15_POLY = 15'h6000;
   localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

   // Fibonacci step: feedback enters at bit 0 and is also the keystream bit.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
      input logic [LFSR_MAX_W-1:0] s,
      input logic [LFSR_MAX_W-1:0] poly,
      input int                    w
   );
      logic [LFSR_MAX_W-1:0] m;
      logic                  fb;
      m  = (w >= LFSR_MAX_W) ? '1 : ((32'd1 << w) - 32'd1);
      fb = ^(s & poly);
      return ((s << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & m;
   endfunction

endpackage

// File: rtl/lfsr_scrambler_lfsr_next.sv
// Combinational N-step LFSR advance producing the per-beat keystream.
// Optional runtime seed load (in the top) is enabled by LFSR_SEED_LOAD_EN.
module lfsr_next
   import scrambler_pkg::*;
#(
   parameter int                LFSR_W = 7,
   parameter logic [LFSR_W-1:0] POLY   = PRBS7_POLY,
   parameter int                N      = 8
) (
   input  logic [LFSR_W-1:0] s_in,
   output logic [LFSR_W-1:0] s_out,
   output logic [N-1:0]      k
);

   logic [LFSR_W-1:0] w_v;

   always_comb begin
      w_v = s_in;
      k   = '0;
      for (int i = 0; i < N; i++) begin
         w_v  = LFSR_W'(lfsr_step(32'(w_v), 32'(POLY), LFSR_W));
         k[i] = w_v[0];
      end
      s_out = w_v;
   end

endmodule

// File: rtl/lfsr_scrambler.sv
// Additive XOR scrambler with registered output and valid/ready on both sides.
// Define LFSR_SEED_LOAD_EN to add the seed_ld/seed_val runtime seed port.
module lfsr_scrambler
   import scrambler_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                LFSR_W = 7,
   parameter logic [LFSR_W-1:0] POLY   = PRBS7_POLY,
   parameter logic [LFSR_W-1:0] SEED   = PRBS7_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              sync,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
`ifdef LFSR_SEED_LOAD_EN
   input  logic              seed_ld,
   input  logic [LFSR_W-1:0] seed_val,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   logic [LFSR_W-1:0] r_state;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   logic              w_acc;
   logic [LFSR_W-1:0] w_start;
   logic [LFSR_W-1:0] w_adv;
   logic [LFSR_W-1:0] w_nxt;
   logic [LFSR_W-1:0] w_nxt_g;
   logic [DATA_W-1:0] w_k;

   assign in_ready  = !r_valid || out_ready;
   assign w_acc     = in_valid && in_ready;
   assign w_start   = sync ? SEED : r_state;
   assign w_nxt     = en ? w_adv : w_start;
   assign w_nxt_g   = (w_nxt == '0) ? SEED : w_nxt;
   assign out_valid = r_valid;
   assign out_data  = r_data;

   lfsr_next #(
      .LFSR_W (LFSR_W),
      .POLY   (POLY),
      .N      (DATA_W)
   ) u_next (
      .s_in  (w_start),
      .s_out (w_adv),
      .k     (w_k)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SEED;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (w_acc) begin
            r_data  <= in_data ^ (en ? w_k : '0);
            r_valid <= 1'b1;
            r_state <= w_nxt_g;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
`ifdef LFSR_SEED_LOAD_EN
         // Runtime seed wins over the advance of a same-cycle beat.
         if (seed_ld) begin
            r_state <= (seed_val == '0) ? SEED : seed_val;
         end
`endif
      end
   end

endmodule
